// File: rtl/vx_barrier_ctrl.sv
// Warp barrier controller: tracks per-ID local wait masks and arrival counts,
// forwards full global barriers to a cross-core arbiter and emits merged release pulses.

module vx_barrier_ctrl_chk #(
  parameter int NUM_WARPS = 4,
  localparam int NW_BITS  = $clog2(NUM_WARPS)
) (
  input logic                 clk,
  input logic                 reset,
  input logic                 bar_valid,
  input logic [NW_BITS-1:0]   bar_wid,
  input logic [NUM_WARPS-1:0] stalled_mask
);

  // A warp that is already waiting must not arrive again; the controller drops it.
  always @(posedge clk) begin
    if (!reset && bar_valid) begin
      assert (!stalled_mask[bar_wid])
        else $warning("vx_barrier_ctrl: duplicate arrival from waiting warp %0d ignored", bar_wid);
    end
  end

endmodule

module vx_barrier_ctrl #(
  parameter int NUM_WARPS    = 4,
  parameter int NUM_BARRIERS = 4,
  localparam int NW_BITS     = $clog2(NUM_WARPS),
  localparam int NB_BITS     = $clog2(NUM_BARRIERS)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 bar_valid,
  input  logic [NW_BITS-1:0]   bar_wid,
  input  logic [NB_BITS-1:0]   bar_id,
  input  logic                 bar_is_global,
  input  logic [NW_BITS-1:0]   bar_size_m1,
  output logic                 gbar_req_valid,
  output logic [NB_BITS-1:0]   gbar_req_id,
  input  logic                 gbar_req_ready,
  input  logic                 gbar_rsp_valid,
  input  logic [NB_BITS-1:0]   gbar_rsp_id,
  output logic                 release_valid,
  output logic [NUM_WARPS-1:0] release_mask,
  output logic [NUM_WARPS-1:0] stalled_mask
);

  logic [NUM_WARPS-1:0] mask_q [NUM_BARRIERS];
  logic [NUM_WARPS-1:0] mask_d [NUM_BARRIERS];
  logic [NW_BITS-1:0]   cnt_q  [NUM_BARRIERS];
  logic [NW_BITS-1:0]   cnt_d  [NUM_BARRIERS];
  logic [NUM_BARRIERS-1:0] gpend_q, gpend_d;

  logic                 rel_valid_q, rel_valid_d;
  logic [NUM_WARPS-1:0] rel_mask_q, rel_mask_d;
  logic [NUM_WARPS-1:0] stalled_q, stalled_d;
  logic                 req_valid_q, req_valid_d;
  logic [NB_BITS-1:0]   req_id_q, req_id_d;

  logic [NUM_WARPS-1:0] wid_bit_s;
  logic                 dup_s;

  assign wid_bit_s = {{(NUM_WARPS-1){1'b0}}, 1'b1} << bar_wid;
  assign dup_s     = |(stalled_q & wid_bit_s);

  // Next-state: response release first, then arrival onto the (possibly fresh) instance.
  always_comb begin
    for (int b = 0; b < NUM_BARRIERS; b++) begin
      mask_d[b] = mask_q[b];
      cnt_d[b]  = cnt_q[b];
    end
    gpend_d     = gpend_q;
    rel_valid_d = 1'b0;
    rel_mask_d  = {NUM_WARPS{1'b0}};
    stalled_d   = {NUM_WARPS{1'b0}};
    req_valid_d = 1'b0;
    req_id_d    = {NB_BITS{1'b0}};

    if (req_valid_q && gbar_req_ready) begin
      gpend_d[req_id_q] = 1'b0;
    end else begin
      gpend_d = gpend_q;
    end

    if (gbar_rsp_valid) begin
      rel_valid_d         = 1'b1;
      rel_mask_d          = mask_q[gbar_rsp_id];
      mask_d[gbar_rsp_id] = {NUM_WARPS{1'b0}};
      cnt_d[gbar_rsp_id]  = {NW_BITS{1'b0}};
    end else begin
      rel_valid_d = 1'b0;
    end

    if (bar_valid && !dup_s) begin
      if (cnt_d[bar_id] != bar_size_m1) begin
        mask_d[bar_id] = mask_d[bar_id] | wid_bit_s;
        cnt_d[bar_id]  = cnt_d[bar_id] + NW_BITS'(1);
      end else if (bar_is_global) begin
        mask_d[bar_id]  = mask_d[bar_id] | wid_bit_s;
        cnt_d[bar_id]   = {NW_BITS{1'b0}};
        gpend_d[bar_id] = 1'b1;
      end else begin
        rel_valid_d    = 1'b1;
        rel_mask_d     = rel_mask_d | mask_d[bar_id] | wid_bit_s;
        mask_d[bar_id] = {NUM_WARPS{1'b0}};
        cnt_d[bar_id]  = {NW_BITS{1'b0}};
      end
    end else begin
      rel_mask_d = rel_mask_d;
    end

    for (int b = 0; b < NUM_BARRIERS; b++) begin
      stalled_d = stalled_d | mask_d[b];
    end

    // An outstanding request is frozen until accepted; otherwise pick the lowest pending ID.
    if (req_valid_q && !gbar_req_ready) begin
      req_valid_d = 1'b1;
      req_id_d    = req_id_q;
    end else begin
      for (int b = NUM_BARRIERS - 1; b >= 0; b--) begin
        if (gpend_d[b]) begin
          req_valid_d = 1'b1;
          req_id_d    = NB_BITS'(b);
        end else begin
          req_id_d    = req_id_d;
        end
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int b = 0; b < NUM_BARRIERS; b++) begin
        mask_q[b] <= {NUM_WARPS{1'b0}};
        cnt_q[b]  <= {NW_BITS{1'b0}};
      end
      gpend_q     <= {NUM_BARRIERS{1'b0}};
      rel_valid_q <= 1'b0;
      rel_mask_q  <= {NUM_WARPS{1'b0}};
      stalled_q   <= {NUM_WARPS{1'b0}};
      req_valid_q <= 1'b0;
      req_id_q    <= {NB_BITS{1'b0}};
    end else begin
      for (int b = 0; b < NUM_BARRIERS; b++) begin
        mask_q[b] <= mask_d[b];
        cnt_q[b]  <= cnt_d[b];
      end
      gpend_q     <= gpend_d;
      rel_valid_q <= rel_valid_d;
      rel_mask_q  <= rel_mask_d;
      stalled_q   <= stalled_d;
      req_valid_q <= req_valid_d;
      req_id_q    <= req_id_d;
    end
  end

  assign release_valid  = rel_valid_q;
  assign release_mask   = rel_mask_q;
  assign stalled_mask   = stalled_q;
  assign gbar_req_valid = req_valid_q;
  assign gbar_req_id    = req_id_q;

  vx_barrier_ctrl_chk #(.NUM_WARPS(NUM_WARPS)) u_chk (
    .clk          (clk),
    .reset        (reset),
    .bar_valid    (bar_valid),
    .bar_wid      (bar_wid),
    .stalled_mask (stalled_q)
  );

endmodule

// File: tb/tb_vx_barrier_ctrl.sv
// Directed bench for vx_barrier_ctrl: release pulses and global requests are checked
// by scoreboard monitors; stall/request levels are checked inline after each edge.

module tb_vx_barrier_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       bar_valid = 1'b0;
  logic [1:0] bar_wid = 2'd0;
  logic [1:0] bar_id = 2'd0;
  logic       bar_is_global = 1'b0;
  logic [1:0] bar_size_m1 = 2'd0;
  logic       gbar_req_valid;
  logic [1:0] gbar_req_id;
  logic       gbar_req_ready = 1'b0;
  logic       gbar_rsp_valid = 1'b0;
  logic [1:0] gbar_rsp_id = 2'd0;
  logic       release_valid;
  logic [3:0] release_mask;
  logic [3:0] stalled_mask;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  typedef struct {
    logic [3:0] mask;
    int         cycle;
  } rel_exp_t;

  rel_exp_t   rel_q[$];
  logic [1:0] req_q[$];

  vx_barrier_ctrl #(.NUM_WARPS(4), .NUM_BARRIERS(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .bar_valid      (bar_valid),
    .bar_wid        (bar_wid),
    .bar_id         (bar_id),
    .bar_is_global  (bar_is_global),
    .bar_size_m1    (bar_size_m1),
    .gbar_req_valid (gbar_req_valid),
    .gbar_req_id    (gbar_req_id),
    .gbar_req_ready (gbar_req_ready),
    .gbar_rsp_valid (gbar_rsp_valid),
    .gbar_rsp_id    (gbar_rsp_id),
    .release_valid  (release_valid),
    .release_mask   (release_mask),
    .stalled_mask   (stalled_mask)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Release monitor: every pulse must match the next expected mask at the expected cycle.
  always @(negedge clk) begin
    if (release_valid) begin
      vectors++;
      if (rel_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_release: got mask %b at cycle %0d, expected no pulse", release_mask, cyc);
      end else begin
        rel_exp_t e;
        e = rel_q.pop_front();
        if (release_mask !== e.mask || cyc != e.cycle) begin
          miscompares++;
          $display("FAIL release: got mask %b at cycle %0d, expected mask %b at cycle %0d",
                   release_mask, cyc, e.mask, e.cycle);
        end
      end
    end
  end

  // Request monitor: each accepted global request must carry the expected ID.
  always @(negedge clk) begin
    if (gbar_req_valid && gbar_req_ready) begin
      vectors++;
      if (req_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_gbar_req: got id %0d, expected no handshake", gbar_req_id);
      end else begin
        logic [1:0] eid;
        eid = req_q.pop_front();
        if (gbar_req_id !== eid) begin
          miscompares++;
          $display("FAIL gbar_req_id: got %0d, expected %0d", gbar_req_id, eid);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  task automatic arrive(input logic [1:0] wid, input logic [1:0] id, input logic glob,
                        input logic [1:0] sz, input logic rsp, input logic [1:0] rid);
    bar_valid      = 1'b1;
    bar_wid        = wid;
    bar_id         = id;
    bar_is_global  = glob;
    bar_size_m1    = sz;
    gbar_rsp_valid = rsp;
    gbar_rsp_id    = rid;
    idle();
    bar_valid      = 1'b0;
    gbar_rsp_valid = 1'b0;
  endtask

  task automatic expect_rel(input logic [3:0] m);
    rel_exp_t e;
    e.mask  = m;
    e.cycle = cyc + 1;
    rel_q.push_back(e);
  endtask

  task automatic handshake(input logic [1:0] id);
    req_q.push_back(id);
    gbar_req_ready = 1'b1;
    idle();
    gbar_req_ready = 1'b0;
  endtask

  task automatic respond(input logic [1:0] id);
    gbar_rsp_valid = 1'b1;
    gbar_rsp_id    = id;
    idle();
    gbar_rsp_valid = 1'b0;
  endtask

  initial begin
    repeat (3) idle();
    chk("reset_release_valid", {3'b000, release_valid}, 4'b0000);
    chk("reset_release_mask", release_mask, 4'b0000);
    chk("reset_stalled", stalled_mask, 4'b0000);
    chk("reset_gbar_req_valid", {3'b000, gbar_req_valid}, 4'b0000);
    chk("reset_gbar_req_id", {2'b00, gbar_req_id}, 4'b0000);
    reset = 1'b0;
    idle();

    // Local barrier, three warps
    arrive(2'd0, 2'd1, 1'b0, 2'd2, 1'b0, 2'd0);
    chk("local_stall1", stalled_mask, 4'b0001);
    arrive(2'd1, 2'd1, 1'b0, 2'd2, 1'b0, 2'd0);
    chk("local_stall2", stalled_mask, 4'b0011);
    expect_rel(4'b0111);
    arrive(2'd2, 2'd1, 1'b0, 2'd2, 1'b0, 2'd0);
    chk("local_stall3", stalled_mask, 4'b0000);

    // Trivial single-warp barrier
    expect_rel(4'b1000);
    arrive(2'd3, 2'd0, 1'b0, 2'd0, 1'b0, 2'd0);
    chk("trivial_stall", stalled_mask, 4'b0000);

    // Global barrier with held request
    arrive(2'd0, 2'd2, 1'b1, 2'd1, 1'b0, 2'd0);
    chk("global_stall1", stalled_mask, 4'b0001);
    chk("global_req_early", {3'b000, gbar_req_valid}, 4'b0000);
    arrive(2'd1, 2'd2, 1'b1, 2'd1, 1'b0, 2'd0);
    chk("global_stall2", stalled_mask, 4'b0011);
    for (int i = 0; i < 3; i++) begin
      chk("global_req_held", {3'b000, gbar_req_valid}, 4'b0001);
      chk("global_req_id_held", {2'b00, gbar_req_id}, 4'b0010);
      idle();
    end
    handshake(2'd2);
    chk("global_req_dropped", {3'b000, gbar_req_valid}, 4'b0000);
    chk("global_stall_wait", stalled_mask, 4'b0011);
    expect_rel(4'b0011);
    respond(2'd2);
    chk("global_stall_rel", stalled_mask, 4'b0000);

    // Merge: local release of id 0 with global response for id 3
    arrive(2'd2, 2'd3, 1'b1, 2'd0, 1'b0, 2'd0);
    chk("merge_req_id", {2'b00, gbar_req_id}, 4'b0011);
    handshake(2'd3);
    arrive(2'd0, 2'd0, 1'b0, 2'd1, 1'b0, 2'd0);
    chk("merge_stall", stalled_mask, 4'b0101);
    expect_rel(4'b0111);
    arrive(2'd1, 2'd0, 1'b0, 2'd1, 1'b1, 2'd3);
    chk("merge_stall_after", stalled_mask, 4'b0000);

    // Arrival and response on the same ID start a fresh instance
    arrive(2'd1, 2'd2, 1'b1, 2'd0, 1'b0, 2'd0);
    handshake(2'd2);
    expect_rel(4'b0010);
    arrive(2'd3, 2'd2, 1'b1, 2'd1, 1'b1, 2'd2);
    chk("fresh_stall", stalled_mask, 4'b1000);
    chk("fresh_no_req", {3'b000, gbar_req_valid}, 4'b0000);
    arrive(2'd2, 2'd2, 1'b1, 2'd1, 1'b0, 2'd0);
    chk("fresh_req", {3'b000, gbar_req_valid}, 4'b0001);
    handshake(2'd2);
    expect_rel(4'b1100);
    respond(2'd2);
    chk("fresh_stall_rel", stalled_mask, 4'b0000);

    // Duplicate arrival is dropped without advancing the count
    arrive(2'd0, 2'd1, 1'b0, 2'd2, 1'b0, 2'd0);
    arrive(2'd0, 2'd1, 1'b0, 2'd2, 1'b0, 2'd0);
    chk("dup_stall", stalled_mask, 4'b0001);
    arrive(2'd1, 2'd1, 1'b0, 2'd2, 1'b0, 2'd0);
    chk("dup_count_kept", stalled_mask, 4'b0011);

    // Asynchronous reset mid-barrier
    #2;
    reset = 1'b1;
    #1;
    chk("areset_stalled", stalled_mask, 4'b0000);
    chk("areset_release_valid", {3'b000, release_valid}, 4'b0000);
    chk("areset_gbar_req_valid", {3'b000, gbar_req_valid}, 4'b0000);
    repeat (2) idle();
    reset = 1'b0;
    repeat (5) idle();
    arrive(2'd2, 2'd1, 1'b0, 2'd2, 1'b0, 2'd0);
    chk("post_reset_stall", stalled_mask, 4'b0100);
    repeat (3) idle();

    chk("pending_releases", rel_q.size() > 0 ? 4'b0001 : 4'b0000, 4'b0000);
    chk("pending_requests", req_q.size() > 0 ? 4'b0001 : 4'b0000, 4'b0000);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no completion by 20000, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/vx_barrier_ctrl.md
VX_BARRIER_CTRL -- requirements
Module: VX_barrier_ctrl

Interface
REQ-001 SHALL have parameter NUM_WARPS, default 4, number of warps in the core (power of two, >=2).
REQ-002 SHALL have parameter NUM_BARRIERS, default 4, number of barrier IDs (power of two, >=2).
REQ-003 SHALL derive NW_BITS = clog2(NUM_WARPS) and NB_BITS = clog2(NUM_BARRIERS).
REQ-004 SHALL use one clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  the clock.
REQ-006 reset  input  1  asynchronous active-high reset.
REQ-007 bar_valid  input  1  single-cycle barrier arrival, always accepted.
REQ-008 bar_wid  input  NW_BITS  arriving warp index.
REQ-009 bar_id  input  NB_BITS  barrier ID.
REQ-010 bar_is_global  input  1  1 = cross-core barrier.
REQ-011 bar_size_m1  input  NW_BITS  participating local warps minus one.
REQ-012 gbar_req_valid  output  1  global barrier request.
REQ-013 gbar_req_id  output  NB_BITS  global barrier ID.
REQ-014 gbar_req_ready  input  1  global request accepted.
REQ-015 gbar_rsp_valid  input  1  single-cycle global release.
REQ-016 gbar_rsp_id  input  NB_BITS  released global barrier ID.
REQ-017 release_valid  output  1  registered release pulse.
REQ-018 release_mask  output  NUM_WARPS  warps to unstall.
REQ-019 stalled_mask  output  NUM_WARPS  warps waiting on any barrier.

Function
REQ-020 SHALL keep, per barrier ID, a local wait mask (NUM_WARPS), an arrival count (NW_BITS) and a global-pending flag.
REQ-021 Local arrival (bar_valid, !bar_is_global) in cycle t with count[id] != size_m1: at t+1 mask[id] gains bit wid and count[id] is incremented.
REQ-022 Local arrival with count[id] == size_m1: at t+1 release_valid=1, release_mask = mask[id] | (1<<wid), and mask[id] and count[id] are cleared.
REQ-023 size_m1 == 0 SHALL release the arriving warp alone at t+1 and never set its stalled bit.
REQ-024 Global arrival in cycle t: at t+1 mask[id] gains bit wid and count[id] is incremented; when the arrival makes count reach size_m1+1, the global-pending flag is set instead of releasing, and count[id] is cleared.
REQ-025 gbar_req_valid SHALL be asserted while any global-pending flag is set, with gbar_req_id equal to the lowest pending ID.
REQ-026 gbar_req_valid and gbar_req_id SHALL hold stable until gbar_req_valid & gbar_req_ready, which clears that flag on the next edge.
REQ-027 gbar_rsp_valid with id k in cycle t: at t+1 release_valid=1, and release_mask includes mask[k]; mask[k] is cleared.
REQ-028 A local release and a global response in the same cycle SHALL be merged into one release pulse with OR'd masks, and both barriers are cleared.
REQ-029 release_valid SHALL be low in every cycle not caused by REQ-022/023/027/028.
REQ-030 stalled_mask SHALL be the registered OR of all wait masks (bits for released warps clear in the same cycle as the release pulse).
REQ-031 An arrival from a warp already set in any wait mask is a protocol error: it SHALL be ignored (no state change) and flagged by a simulation assertion.
REQ-032 An arrival at barrier j and a release of barrier k != j in the same cycle SHALL both take effect.
REQ-033 An arrival and a gbar_rsp for the same ID in the same cycle: the response releases the previous mask; the new arrival starts a fresh barrier instance (mask = 1<<wid, count = 1).

Reset
REQ-034 On reset all masks, counts and pending flags SHALL clear asynchronously; release_valid=0, release_mask=0, stalled_mask=0, gbar_req_valid=0, gbar_req_id=0.
REQ-035 Reset asserted mid-barrier SHALL discard all waiting warps with no release pulse after deassertion.

Verification
REQ-036 Local: warps 0,1,2 arrive on id 1 with size_m1=2 in cycles 0,1,2 -> stalled_mask 0001, 0011 after cycles 1, 2; in cycle 3 release_valid=1, release_mask=0111, stalled_mask=0000.
REQ-037 Trivial: warp 3, id 0, size_m1=0 -> next cycle release_mask=1000, stalled_mask stays 0000.
REQ-038 Global: warps 0,1 arrive on id 2 global with size_m1=1 -> gbar_req_valid=1 with id 2 and held while ready=0 for 3 cycles; ready=1 drops it; gbar_rsp id 2 -> release_mask=0011.
REQ-039 Merge: local release of id 0 (warps 0,1) coincides with gbar_rsp id 3 (warp 2) -> single pulse, release_mask=0111.
REQ-040 Error/reset: warp 0 arrives twice on id 1 -> second ignored, count stays 1; reset asserted asynchronously -> all outputs 0 immediately, no pulse afterwards.
